timer_sequencer: RTL and testbench

//  Sequences and configures the free-running period timer. Owns the timer's

---
 rtl/timer_pkg.sv | 18 +
 rtl/timer_sequencer_btn_edge.sv | 68 ++++++
 rtl/timer_sequencer.sv | 159 +++++++++++++++
 tb/tb_timer_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and period defaults for the timer sequencer
// Purpose: sequencer state enum plus the period/step defaults also used by the timer.
// Ports: none (package).
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned TIMER_CNT_W      = 65;
  localparam int unsigned TIMER_STEP       = 5000000;
  localparam int unsigned TIMER_MIN_PERIOD = 5000000;
  localparam int unsigned TIMER_MAX_PERIOD = 50000000;

endpackage

// File: rtl/timer_sequencer_btn_edge.sv
// rtl/timer_sequencer_btn_edge.sv - optional debounce filter followed by rising-edge detect
// Purpose: turns a level input into a one-clock rise pulse. With TIMER_SEQ_DEBOUNCE_EN
//   defined the input must hold a new level for DEB_CYCLES clocks before it is accepted.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   din   in  raw level input
//   rise  out one-clock pulse on an accepted 0->1 transition (combinational from regs + din)
module btn_edge #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic filt;
  logic prev_q, prev_d;

`ifdef TIMER_SEQ_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  // Flip on the DEB_CYCLES-th differing sample so the edge acts DEB_CYCLES+1 clks after settling.
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (din != stable_q) begin
      if (cnt_q >= DEB_LAST) begin
        stable_d = din;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign filt = stable_q;
`else
  assign filt = din;
`endif

  assign prev_d = filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = filt & ~prev_q;

endmodule

// File: rtl/timer_sequencer.sv
// rtl/timer_sequencer.sv - burst/loop sequencer and period control for the period timer
// Purpose: drives the timer's clr/run/maxcount, counts terminal ticks (yes) into one-shot
//   or looping bursts, and steps the period on inc/dec rises with saturation.
//   Optional macro: TIMER_SEQ_DEBOUNCE_EN (debounce strtcntr/inc/dec before edge detect).
// Ports:
//   clk, reset (async active-low)
//   strtcntr, Loop, stop, inc, dec, repeats[REP_W], yes       inputs
//   clr, run, maxcount[CNT_W], remaining[REP_W], busy, done    registered outputs
module timer_sequencer
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W      = TIMER_CNT_W,
  parameter int unsigned STEP       = TIMER_STEP,
  parameter int unsigned MIN_PERIOD = TIMER_MIN_PERIOD,
  parameter int unsigned MAX_PERIOD = TIMER_MAX_PERIOD,
  parameter int unsigned REP_W      = 8,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strtcntr,
  input  logic             Loop,
  input  logic             stop,
  input  logic             inc,
  input  logic             dec,
  input  logic [REP_W-1:0] repeats,
  input  logic             yes,
  output logic             clr,
  output logic             run,
  output logic [CNT_W-1:0] maxcount,
  output logic [REP_W-1:0] remaining,
  output logic             busy,
  output logic             done
);

  // One extra bit so inc overflow / dec underflow are seen before truncation.
  localparam logic [CNT_W:0]   STEP_X = (CNT_W + 1)'(STEP);
  localparam logic [CNT_W:0]   MIN_X  = (CNT_W + 1)'(MIN_PERIOD);
  localparam logic [CNT_W:0]   MAX_X  = (CNT_W + 1)'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] MIN_N  = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_N  = CNT_W'(MAX_PERIOD);

  logic strt_rise, inc_rise, dec_rise;

  btn_edge #(.DEB_CYCLES(DEB_CYCLES)) u_strt_edge (
    .clk(clk), .rst_n(reset), .din(strtcntr), .rise(strt_rise)
  );
  btn_edge #(.DEB_CYCLES(DEB_CYCLES)) u_inc_edge (
    .clk(clk), .rst_n(reset), .din(inc), .rise(inc_rise)
  );
  btn_edge #(.DEB_CYCLES(DEB_CYCLES)) u_dec_edge (
    .clk(clk), .rst_n(reset), .din(dec), .rise(dec_rise)
  );

  state_t           state_q, state_d;
  logic [REP_W-1:0] rem_q, rem_d;
  logic [REP_W-1:0] reload_q, reload_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] maxcount_q, maxcount_d;
  logic             clr_q, clr_d;
  logic             run_q, run_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W:0]   pend_x, sum_x, diff_x;

  // Period register: saturating steps; simultaneous inc and dec cancel.
  always_comb begin
    pend_x    = {1'b0, pending_q};
    sum_x     = pend_x + STEP_X;
    diff_x    = pend_x - STEP_X;
    pending_d = pending_q;
    if (inc_rise && !dec_rise) begin
      pending_d = (sum_x > MAX_X) ? MAX_N : sum_x[CNT_W-1:0];
    end else if (dec_rise && !inc_rise) begin
      pending_d = (diff_x[CNT_W] || (diff_x < MIN_X)) ? MIN_N : diff_x[CNT_W-1:0];
    end
  end

  // A new period only takes effect on a tick boundary while running.
  always_comb begin
    maxcount_d = maxcount_q;
    if ((state_q != ST_RUN) || yes) begin
      maxcount_d = pending_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    reload_d = reload_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (strt_rise) state_d = ST_ARM;
        ST_ARM: begin
          state_d  = ST_RUN;
          reload_d = (repeats == '0) ? REP_W'(1) : repeats;
          rem_d    = reload_d;
        end
        ST_RUN: begin
          if (yes) begin
            if (rem_q <= REP_W'(1)) begin
              if (Loop) begin
                rem_d = reload_q;
              end else begin
                rem_d   = '0;
                state_d = ST_DONE;
              end
            end else begin
              rem_d = rem_q - 1'b1;
            end
          end
        end
        ST_DONE: if (strt_rise) state_d = ST_ARM;
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they change together with it.
    clr_d  = (state_d != ST_RUN);
    run_d  = (state_d == ST_RUN);
    busy_d = (state_d == ST_ARM) || (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      reload_q   <= REP_W'(1);
      pending_q  <= MAX_N;
      maxcount_q <= MAX_N;
      clr_q      <= 1'b1;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      reload_q   <= reload_d;
      pending_q  <= pending_d;
      maxcount_q <= maxcount_d;
      clr_q      <= clr_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign clr       = clr_q;
  assign run       = run_q;
  assign maxcount  = maxcount_q;
  assign remaining = rem_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// tb/tb_timer_sequencer.sv - directed table-driven bench for timer_sequencer
module tb_timer_sequencer;

  localparam int unsigned CNT_W = 65;
  localparam longint P50 = 50000000;
  localparam longint P45 = 45000000;
  localparam longint P5  = 5000000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             strtcntr = 1'b0, Loop = 1'b0, stop = 1'b0;
  logic             inc = 1'b0, dec = 1'b0, yes = 1'b0;
  logic [7:0]       repeats = 8'd0;
  logic             clr, run, busy, done;
  logic [CNT_W-1:0] maxcount;
  logic [7:0]       remaining;

  int checks = 0;
  int errors = 0;

  timer_sequencer dut (
    .clk(clk), .reset(reset), .strtcntr(strtcntr), .Loop(Loop), .stop(stop),
    .inc(inc), .dec(dec), .repeats(repeats), .yes(yes),
    .clr(clr), .run(run), .maxcount(maxcount), .remaining(remaining),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       strt, lp, stp, y;
    logic [7:0] rep;
    logic       e_clr, e_run, e_busy, e_done;
    logic       chk_rem;
    logic [7:0] e_rem;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic s, logic l, logic p, logic y, logic [7:0] r,
                              logic c, logic rn, logic b, logic d, logic cr, logic [7:0] er);
    vec_t v;
    v.strt = s; v.lp = l; v.stp = p; v.y = y; v.rep = r;
    v.e_clr = c; v.e_run = rn; v.e_busy = b; v.e_done = d; v.chk_rem = cr; v.e_rem = er;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic c, input logic rn, input logic b,
                          input logic d, input longint mx);
    chk({tag, ".clr"}, longint'(clr), longint'(c));
    chk({tag, ".run"}, longint'(run), longint'(rn));
    chk({tag, ".busy"}, longint'(busy), longint'(b));
    chk({tag, ".done"}, longint'(done), longint'(d));
    chk({tag, ".maxcount"}, longint'(maxcount), mx);
  endtask

  task automatic pulse_period(input logic i, input logic d);
    inc = i; dec = d;
    tick();
    inc = 1'b0; dec = 1'b0;
  endtask

  initial begin
    //     strt lp stp y rep    clr run busy done chk rem
    vq.push_back(mk(0, 0, 0, 0, 3,  1, 0, 0, 0, 1, 0)); // 0 idle
    vq.push_back(mk(1, 0, 0, 0, 3,  1, 0, 1, 0, 1, 0)); // 1 ARM
    vq.push_back(mk(1, 0, 0, 0, 3,  0, 1, 1, 0, 1, 3)); // 2 RUN rem 3
    vq.push_back(mk(1, 0, 0, 1, 3,  0, 1, 1, 0, 1, 2)); // 3
    vq.push_back(mk(1, 0, 0, 0, 3,  0, 1, 1, 0, 1, 2)); // 4
    vq.push_back(mk(1, 0, 0, 1, 3,  0, 1, 1, 0, 1, 1)); // 5
    vq.push_back(mk(1, 0, 0, 1, 3,  1, 0, 0, 1, 1, 0)); // 6 DONE
    vq.push_back(mk(1, 0, 0, 0, 3,  1, 0, 0, 1, 1, 0)); // 7 held strt: no restart
    vq.push_back(mk(0, 0, 0, 0, 3,  1, 0, 0, 1, 1, 0)); // 8
    vq.push_back(mk(1, 1, 0, 0, 0,  1, 0, 1, 0, 1, 0)); // 9 DONE->ARM, repeats 0
    vq.push_back(mk(0, 1, 0, 0, 0,  0, 1, 1, 0, 1, 1)); // 10 0 treated as 1
    vq.push_back(mk(0, 1, 0, 1, 0,  0, 1, 1, 0, 1, 1)); // 11 loop reload
    vq.push_back(mk(1, 1, 0, 1, 0,  0, 1, 1, 0, 1, 1)); // 12 rise in RUN ignored
    vq.push_back(mk(1, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0)); // 13 stop
    vq.push_back(mk(0, 1, 0, 0, 2,  1, 0, 0, 0, 0, 0)); // 14
    vq.push_back(mk(1, 1, 0, 0, 2,  1, 0, 1, 0, 0, 0)); // 15 ARM
    vq.push_back(mk(0, 1, 0, 0, 2,  0, 1, 1, 0, 1, 2)); // 16
    vq.push_back(mk(0, 1, 0, 1, 2,  0, 1, 1, 0, 1, 1)); // 17
    vq.push_back(mk(0, 1, 0, 1, 2,  0, 1, 1, 0, 1, 2)); // 18 reloaded
    vq.push_back(mk(0, 1, 0, 1, 2,  0, 1, 1, 0, 1, 1)); // 19
    vq.push_back(mk(0, 0, 1, 1, 2,  1, 0, 0, 0, 0, 0)); // 20 stop beats final yes
    vq.push_back(mk(0, 0, 0, 1, 2,  1, 0, 0, 0, 0, 0)); // 21 yes in IDLE ignored
    vq.push_back(mk(1, 0, 1, 0, 2,  1, 0, 0, 0, 0, 0)); // 22 stop beats start rise
    vq.push_back(mk(1, 0, 0, 0, 2,  1, 0, 0, 0, 0, 0)); // 23 no new rise
    vq.push_back(mk(0, 0, 0, 0, 2,  1, 0, 0, 0, 0, 0)); // 24

    // Reset state
    tick();
    tick();
    chk_outs("reset", 1, 0, 0, 0, P50);
    chk("reset.remaining", longint'(remaining), 0);
    reset = 1'b1;

    foreach (vq[i]) begin
      strtcntr = vq[i].strt; Loop = vq[i].lp; stop = vq[i].stp;
      yes = vq[i].y; repeats = vq[i].rep;
      tick();
      chk_outs($sformatf("vec%0d", i), vq[i].e_clr, vq[i].e_run, vq[i].e_busy,
               vq[i].e_done, P50);
      if (vq[i].chk_rem) chk($sformatf("vec%0d.remaining", i), longint'(remaining),
                             longint'(vq[i].e_rem));
    end
    strtcntr = 0; Loop = 0; stop = 0; yes = 0;
    tick();

    // Saturating period steps
    for (int k = 1; k <= 11; k++) begin
      longint e;
      pulse_period(0, 1);
      e = P50 - P5 * k;
      if (e < P5) e = P5;
      chk($sformatf("dec%0d", k), longint'(maxcount), e);
      tick();
    end
    for (int k = 1; k <= 12; k++) begin
      longint e;
      pulse_period(1, 0);
      e = P5 + P5 * k;
      if (e > P50) e = P50;
      chk($sformatf("inc%0d", k), longint'(maxcount), e);
      tick();
    end
    pulse_period(0, 1);
    chk("dec_before_both", longint'(maxcount), P45);
    tick();
    pulse_period(1, 1);
    chk("inc_dec_same", longint'(maxcount), P45);
    tick();
    pulse_period(1, 0);
    chk("inc_back_50m", longint'(maxcount), P50);
    tick();

    // Period change while running waits for the next yes
    strtcntr = 1; repeats = 2;
    tick();
    chk("p5.arm_busy", longint'(busy), 1);
    strtcntr = 0;
    tick();
    chk("p5.run", longint'(run), 1);
    chk("p5.rem", longint'(remaining), 2);
    pulse_period(0, 1);
    chk("p5.hold_after_dec", longint'(maxcount), P50);
    tick();
    chk("p5.hold_later", longint'(maxcount), P50);
    yes = 1;
    tick();
    yes = 0;
    chk("p5.apply_on_yes", longint'(maxcount), P45);
    chk("p5.rem_after_yes", longint'(remaining), 1);
    chk("p5.still_run", longint'(run), 1);

    // Asynchronous reset mid-RUN
    #2 reset = 1'b0;
    #1;
    chk_outs("rst_async", 1, 0, 0, 0, P50);
    tick();
    chk_outs("rst_clk", 1, 0, 0, 0, P50);
    chk("rst_clk.remaining", longint'(remaining), 0);
    reset = 1'b1;
    tick();
    chk_outs("rst_release", 1, 0, 0, 0, P50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
